// File: rtl/conv_tap_accumulator_if.sv
// Handshake bundle between the multiplier, the tap accumulator and the
// feature-map writer.
//   in_data/in_valid/in_ready     : product stream into the accumulator
//   out_data/out_sat/out_valid/out_ready : result stream toward the writer
// Modports:
//   slave  : the accumulator side (consumes products, produces results)
//   master : the environment side (produces products, consumes results)
interface conv_tap_accumulator_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/conv_tap_accumulator.sv
// Convolution tap accumulator: sums a programmable number of signed products
// plus a bias, then applies an arithmetic scale shift, optional ReLU and
// signed saturation. The result is held on a valid/ready output until taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort of the current window / pending result
//   taps       : products per output (0 acts as 1), sampled on the first tap
//   bias       : signed bias, sampled on the first tap
//   relu_en    : clamp negative results to zero, sampled on the first tap
//   bus        : product input and result output handshakes (slave side)
module conv_tap_accumulator #(
  parameter int IN_W      = 16,
  parameter int BIAS_W    = 16,
  parameter int ACC_W     = 26,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [7:0]           taps,
  input  logic [BIAS_W-1:0]    bias,
  input  logic                 relu_en,
  conv_tap_accumulator_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  // Largest / smallest representable output, widened to the accumulator.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [7:0]              cnt_q;
  logic [7:0]              taps_q;
  logic                    relu_q;
  logic [OUT_W-1:0]        out_data_q;
  logic                    out_sat_q;
  logic                    out_valid_q;

  logic                    in_fire;
  logic [7:0]              taps_eff;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] clamped;
  logic                    relu_sel;
  logic                    last_tap;
  logic [OUT_W-1:0]        res_data;
  logic                    res_sat;

  assign bus.in_ready  = (state_q != S_HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_valid = out_valid_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign taps_eff = (taps == 8'd0) ? 8'd1 : taps;
  assign in_ext   = ACC_W'($signed(bus.in_data));
  assign bias_ext = ACC_W'($signed(bias));

  // The result is formed from the sum that includes the tap being accepted,
  // so the first tap uses the live relu_en and later taps the latched copy.
  always_comb begin
    acc_d    = (state_q == S_IDLE) ? (bias_ext + in_ext) : (acc_q + in_ext);
    relu_sel = (state_q == S_IDLE) ? relu_en : relu_q;
    last_tap = (state_q == S_IDLE) ? (taps_eff == 8'd1)
                                   : ((cnt_q + 8'd1) == taps_q);
    shifted  = acc_d >>> OUT_SHIFT;
    clamped  = (relu_sel && shifted[ACC_W-1]) ? '0 : shifted;
    res_data = clamped[OUT_W-1:0];
    res_sat  = 1'b0;
    if (clamped > SAT_MAX) begin
      res_data = SAT_MAX[OUT_W-1:0];
      res_sat  = 1'b1;
    end else if (clamped < SAT_MIN) begin
      res_data = SAT_MIN[OUT_W-1:0];
      res_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      taps_q      <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            taps_q <= taps_eff;
            relu_q <= relu_en;
            acc_q  <= acc_d;
            cnt_q  <= 8'd1;
            if (last_tap) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= res_data;
              out_sat_q   <= res_sat;
            end else begin
              state_q <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (in_fire) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 8'd1;
            if (last_tap) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= res_data;
              out_sat_q   <= res_sat;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tap_accumulator.sv
module tb_conv_tap_accumulator;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int SH    = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  taps;
  logic [15:0] bias;
  logic        relu_en;

  conv_tap_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  conv_tap_accumulator #(
    .IN_W(IN_W), .BIAS_W(16), .ACC_W(26), .OUT_W(OUT_W), .OUT_SHIFT(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .taps(taps), .bias(bias),
    .relu_en(relu_en), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int taps;
    int bias;
    bit relu;
    int n;
    int d[9];
    int exp_data;
    bit exp_sat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int odata();
    return int'($signed(bus.out_data));
  endfunction

  // Reference: plain integer arithmetic over the whole window.
  function automatic void model(input int b, input bit r, input int d[$],
                                output int ed, output bit es);
    longint s = b;
    foreach (d[i]) s += d[i];
    s = s >>> SH;
    if (r && s < 0) s = 0;
    es = 1'b0;
    if (s > 32767) begin s = 32767; es = 1'b1; end
    else if (s < -32768) begin s = -32768; es = 1'b1; end
    ed = int'(s);
  endfunction

  // Called at a negedge; returns at the negedge after the tap was accepted.
  task automatic send(input int d, input string name);
    int n = 0;
    bus.in_data  = 16'(d);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({name, " in_ready timeout"}, 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Sends a window; configuration is scrambled after the first tap.
  task automatic window(input int t, input int b, input bit r, input int d[$],
                        input bit gaps, input string name);
    taps = 8'(t); bias = 16'(b); relu_en = r;
    foreach (d[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) @(negedge clk);
      send(d[i], name);
      taps = 8'($urandom); bias = 16'($urandom); relu_en = 1'($urandom);
    end
  endtask

  task automatic collect(input int ed, input bit es, input bit rnd,
                         input string name);
    int n = 0;
    forever begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) break;
      if (n++ > 200) break;
      @(negedge clk);
    end
    if (n > 200) check({name, " out_valid timeout"}, 0, 1);
    check({name, " data"}, odata(), ed);
    check({name, " sat"}, int'(bus.out_sat), int'(es));
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int q[$];
    int ed;
    bit es;
    int t;

    tbl[0] = '{9, 10, 0, 9, '{1,2,3,4,5,6,7,8,9}, 55, 0};
    tbl[1] = '{3, 0, 0, 3, '{-100,-200,50,0,0,0,0,0,0}, -250, 0};
    tbl[2] = '{3, 0, 1, 3, '{-100,-200,50,0,0,0,0,0,0}, 0, 0};
    tbl[3] = '{4, 0, 0, 4, '{32767,32767,32767,32767,0,0,0,0,0}, 32767, 1};
    tbl[4] = '{4, 0, 0, 4, '{-32768,-32768,-32768,-32768,0,0,0,0,0}, -32768, 1};
    tbl[5] = '{0, 3, 0, 1, '{4,0,0,0,0,0,0,0,0}, 7, 0};
    tbl[6] = '{2, 32767, 0, 2, '{1,0,0,0,0,0,0,0,0}, 32767, 1};
    tbl[7] = '{2, -32768, 1, 2, '{-1,0,0,0,0,0,0,0,0}, 0, 0};

    rst_n = 1'b0; clear = 1'b0; taps = '0; bias = '0; relu_en = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset out_data", int'(bus.out_data), 0);
    check("reset out_sat", int'(bus.out_sat), 0);
    check("reset in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, with latency and single-cycle valid checks.
    for (int v = 0; v < 8; v++) begin
      q.delete();
      for (int i = 0; i < tbl[v].n; i++) q.push_back(tbl[v].d[i]);
      bus.out_ready = 1'b1;
      window(tbl[v].taps, tbl[v].bias, tbl[v].relu, q, 1'b0, "tbl");
      check("tbl latency out_valid", int'(bus.out_valid), 1);
      check("tbl data", odata(), tbl[v].exp_data);
      check("tbl sat", int'(bus.out_sat), int'(tbl[v].exp_sat));
      @(negedge clk);
      check("tbl valid one cycle", int'(bus.out_valid), 0);
      check("tbl data kept", odata(), tbl[v].exp_data);
      bus.out_ready = 1'b0;
    end

    // Backpressure in HOLD, then the one-cycle bubble.
    taps = 8'd1; bias = 16'd5; relu_en = 1'b0;
    send(7, "hold");
    taps = 8'd1; bias = 16'd0;
    bus.in_data = 16'd100; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold out_valid", int'(bus.out_valid), 1);
      check("hold data", odata(), 12);
      check("hold in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bubble out_valid", int'(bus.out_valid), 0);
    check("bubble in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("after bubble out_valid", int'(bus.out_valid), 1);
    check("after bubble data", odata(), 100);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Gapped window.
    q = '{2,2,2,2,2,2,2,2,2};
    taps = 8'd9; bias = -16'sd18; relu_en = 1'b0;
    foreach (q[i]) begin
      send(q[i], "gap");
      @(negedge clk);
    end
    collect(0, 0, 0, "gap");

    // Clear after 4 taps (with a discarded input in the same cycle).
    q = '{50,50,50,50};
    window(9, 0, 0, q, 1'b0, "clr");
    clear = 1'b1; bus.in_data = 16'd999; bus.in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; bus.in_valid = 1'b0;
    check("clear out_valid", int'(bus.out_valid), 0);
    check("clear in_ready", int'(bus.in_ready), 1);
    q = '{3,3,3,3,3,3,3,3,3};
    window(9, 0, 0, q, 1'b0, "clr fresh");
    collect(27, 0, 0, "clr fresh");

    // Clear while holding a result: valid drops, data kept.
    q = '{11};
    window(1, 0, 0, q, 1'b0, "clrhold");
    clear = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; bus.out_ready = 1'b0;
    check("clrhold out_valid", int'(bus.out_valid), 0);
    check("clrhold data kept", odata(), 11);

    // Asynchronous reset mid-window.
    q = '{1,1,1,1,1};
    window(9, 0, 0, q, 1'b0, "rst");
    #2 rst_n = 1'b0;
    #1;
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst in_ready", int'(bus.in_ready), 1);
    check("rst out_data", int'(bus.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = '{4,6};
    window(2, 0, 0, q, 1'b0, "rst after");
    collect(10, 0, 0, "rst after");

    // Randomized windows against the reference model.
    for (int w = 0; w < 40; w++) begin
      int b;
      bit r;
      t = $urandom_range(0, 12);
      b = $signed(16'($urandom));
      r = 1'($urandom);
      q.delete();
      for (int i = 0; i < ((t == 0) ? 1 : t); i++) begin
        if ($urandom_range(0, 1) == 1) q.push_back($signed(16'($urandom)));
        else q.push_back($urandom_range(0, 2000) - 1000);
      end
      model(b, r, q, ed, es);
      window(t, b, r, q, 1'b1, "rand");
      collect(ed, es, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
